axi_stream_header_arbiter: RTL and testbench
============================================

AXI_STREAM_HEADER_ARBITER -- requirements
Module: axi_stream_header_arbiter

Interface
REQ-001 Parameter DATA_WD, default 32, SHALL set the header width in bits.
REQ-002 Parameter DATA_BYTE_WD, default DATA_WD/8, SHALL set the keep width.
REQ-003 Parameter N_SRC, default 4, SHALL set the number of header requesters (2..8).
REQ-004 Parameter EOP_TIMEOUT, default 1024, SHALL set the maximum cycles spent waiting for end of packet.
REQ-005 Ports (clock and reset first): one clock; reset is asynchronous and active-high.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  N_SRC  per-source header valid.
- req_header  in  N_SRC*DATA_WD  packed headers; source i occupies bits [i*DATA_WD +: DATA_WD].
- req_keep  in  N_SRC*DATA_BYTE_WD  packed header keeps.
- req_ready  out  N_SRC  per-source accept, at most one bit high.
- valid_insert  out  1  header valid to inserter.
- header_insert  out  DATA_WD  granted header.
- keep_insert  out  DATA_BYTE_WD  granted keep.
- ready_insert  in  1  inserter header accept.
- mon_valid  in  1  inserter output valid_out, observe only.
- mon_ready  in  1  inserter output ready_out, observe only.
- mon_last  in  1  inserter output last_out, observe only.
- grant_id  out  $clog2(N_SRC)  index of the current owner.
- busy  out  1  high in any state other than IDLE.
- timeout_pulse  out  1  one-cycle flag on EOP timeout.
- keep_err  out  1  one-cycle flag when a captured keep is not right-aligned contiguous.

Function
REQ-006 FSM states SHALL be IDLE, OFFER and WAIT_EOP.
REQ-007 In IDLE, req_ready SHALL be combinational one-hot for the first asserted req_valid, searching upward from rr_ptr with wrap-around.
REQ-008 In IDLE, on any req_valid, the arbiter SHALL:
- register the winner's header, keep and index (grant_id);
- move to OFFER the next cycle.
Request-to-valid_insert latency is therefore 1 cycle.
REQ-009 In OFFER, valid_insert SHALL be 1 with registered header and keep held stable until ready_insert=1.
REQ-010 An OFFER handshake (valid_insert && ready_insert) SHALL move the FSM to WAIT_EOP, or straight to IDLE if mon_valid&&mon_ready&&mon_last occurs in the same cycle.
REQ-011 In WAIT_EOP, valid_insert SHALL be 0; on mon_valid&&mon_ready&&mon_last the FSM SHALL return to IDLE.
REQ-012 On each return to IDLE, rr_ptr SHALL become (grant_id+1) mod N_SRC; a source that was just served SHALL therefore have lowest priority next.
REQ-013 A WAIT_EOP cycle counter SHALL:
- clear on entry to WAIT_EOP;
- on reaching EOP_TIMEOUT-1 without EOP, force IDLE, pulse timeout_pulse and advance rr_ptr as in REQ-012.
REQ-014 A captured keep outside {all-ones, right-aligned contiguous ones, zero} SHALL pulse keep_err one cycle after capture and SHALL be forwarded unchanged.
REQ-015 Sources not granted SHALL see req_ready=0; req_valid deassertion by any source SHALL NOT affect an already captured grant.
REQ-016 An mon_last beat seen in IDLE SHALL be ignored.

Reset
REQ-017 On rst, the block SHALL set state=IDLE, rr_ptr=0, grant_id=0, header/keep registers=0, counter=0.
REQ-018 On rst, valid_insert, busy, timeout_pulse and keep_err SHALL be 0; req_ready SHALL be 0 while rst is high.
REQ-019 Reset asserted mid-packet SHALL abandon the grant with no output pulse.

Structure
REQ-020 A shared package SHALL hold the state enum, default DATA_WD and the legal-keep check function.
REQ-021 The round-robin priority picker SHALL be one sub-module, rr_pick (inputs req and ptr; output one-hot and index).

Verification
REQ-022 Scenario: req_valid=4'b0001, header 0xA1B2C3D4, keep 4'b1111, ready_insert=1 -> req_ready[0] pulses in cycle 0, valid_insert=1 with 0xA1B2C3D4 in cycle 1, WAIT_EOP until mon_last handshake, then IDLE.
REQ-023 Scenario: all four sources valid continuously, EOP 5 cycles after each grant -> grant order 0,1,2,3,0.
REQ-024 Scenario: ready_insert held 0 for 7 cycles in OFFER -> valid_insert, header and keep stable for all 7 cycles; no other req_ready asserted.
REQ-025 Scenario: EOP_TIMEOUT=16, no mon_last -> timeout_pulse exactly once, 16 cycles after WAIT_EOP entry; next grant goes to the next source.
REQ-026 Scenario: keep 4'b0101 from source 2 -> keep_err pulse, keep_insert=4'b0101 forwarded.
REQ-027 Scenario: rst asserted in WAIT_EOP -> all outputs 0 immediately; after release, source 0 is granted first.

Source files
------------

// File: rtl/axi_stream_header_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_stream_header_arbiter_pkg
// Brief   : Shared state encoding, default width and keep-legality helper.
// Revision: 1.0
// ============================================================================
package axi_stream_header_arbiter_pkg;

    localparam int c_default_data_wd = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OFFER    = 2'd1,
        ST_WAIT_EOP = 2'd2
    } state_t;

    // Legal keeps are 0, all-ones or LSB-anchored contiguous ones: k+1 is a power of two.
    function automatic logic keep_is_legal(input logic [63:0] keep);
        return ((keep + 64'd1) & keep) == 64'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_stream_header_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : axi_stream_header_arbiter_if
// Brief   : Requester, inserter and monitor handshake bundle.
// Revision: 1.0
// ============================================================================
interface axi_stream_header_arbiter_if
    import axi_stream_header_arbiter_pkg::*;
#(
    parameter int DATA_WD      = c_default_data_wd,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int N_SRC        = 4
);
    logic [N_SRC-1:0]              req_valid;
    logic [N_SRC*DATA_WD-1:0]      req_header;
    logic [N_SRC*DATA_BYTE_WD-1:0] req_keep;
    logic [N_SRC-1:0]              req_ready;
    logic                          valid_insert;
    logic [DATA_WD-1:0]            header_insert;
    logic [DATA_BYTE_WD-1:0]       keep_insert;
    logic                          ready_insert;
    logic                          mon_valid;
    logic                          mon_ready;
    logic                          mon_last;

    modport master (
        input  req_valid, req_header, req_keep, ready_insert,
               mon_valid, mon_ready, mon_last,
        output req_ready, valid_insert, header_insert, keep_insert
    );

    modport slave (
        output req_valid, req_header, req_keep, ready_insert,
               mon_valid, mon_ready, mon_last,
        input  req_ready, valid_insert, header_insert, keep_insert
    );

endinterface
`default_nettype wire

// File: rtl/axi_stream_header_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Round-robin picker; first request at or above ptr, with wrap.
// Revision: 1.0
// ============================================================================
module rr_pick #(
    parameter int N_SRC  = 4,
    parameter int IDX_WD = 2
) (
    input  logic [N_SRC-1:0]  req,
    input  logic [IDX_WD-1:0] ptr,
    output logic [N_SRC-1:0]  onehot,
    output logic [IDX_WD-1:0] idx
);
    int w_best;

    // The winner is the requester with the smallest wrapped distance from ptr.
    always_comb begin
        w_best = N_SRC;
        idx    = '0;
        onehot = '0;
        for (int j = 0; j < N_SRC; j++) begin
            if (req[j] && (((j + N_SRC - int'(ptr)) % N_SRC) < w_best)) begin
                w_best = (j + N_SRC - int'(ptr)) % N_SRC;
                idx    = IDX_WD'(j);
            end
        end
        for (int j = 0; j < N_SRC; j++) begin
            onehot[j] = (w_best < N_SRC) && (idx == IDX_WD'(j));
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_stream_header_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : axi_stream_header_arbiter
// Brief   : Grants one of N_SRC header requesters to the inserter per packet.
// Revision: 1.0
// ============================================================================
module axi_stream_header_arbiter
    import axi_stream_header_arbiter_pkg::*;
#(
    parameter int DATA_WD      = c_default_data_wd,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int N_SRC        = 4,
    parameter int EOP_TIMEOUT  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    axi_stream_header_arbiter_if.master bus,
    output logic [$clog2(N_SRC)-1:0]   grant_id,
    output logic                       busy,
    output logic                       timeout_pulse,
    output logic                       keep_err
);
    localparam int                    c_idx_wd   = $clog2(N_SRC);
    localparam int                    c_cnt_wd   = $clog2(EOP_TIMEOUT);
    localparam logic [c_cnt_wd-1:0]   c_cnt_last = c_cnt_wd'(EOP_TIMEOUT - 1);

    state_t                  r_state, w_next_state;
    logic [c_idx_wd-1:0]     r_rr_ptr, r_grant_id, w_pick_idx;
    logic [N_SRC-1:0]        w_pick_onehot;
    logic [DATA_WD-1:0]      r_header, w_win_header;
    logic [DATA_BYTE_WD-1:0] r_keep, w_win_keep;
    logic [c_cnt_wd-1:0]     r_cnt;
    logic                    r_timeout_pulse, r_keep_err;
    logic                    w_eop, w_capture, w_enter_wait, w_release, w_timeout;

    rr_pick #(.N_SRC(N_SRC), .IDX_WD(c_idx_wd)) u_rr_pick (
        .req    (bus.req_valid),
        .ptr    (r_rr_ptr),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx)
    );

    always_comb begin
        w_win_header = '0;
        w_win_keep   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_pick_onehot[i]) begin
                w_win_header = bus.req_header[i*DATA_WD +: DATA_WD];
                w_win_keep   = bus.req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
            end
        end
    end

    assign w_eop = bus.mon_valid & bus.mon_ready & bus.mon_last;

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_enter_wait = 1'b0;
        w_release    = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (bus.ready_insert) begin
                    if (w_eop) begin
                        w_release    = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_enter_wait = 1'b1;
                        w_next_state = ST_WAIT_EOP;
                    end
                end
            end
            ST_WAIT_EOP: begin
                if (w_eop) begin
                    w_release    = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout    = 1'b1;
                    w_release    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_rr_ptr        <= '0;
            r_grant_id      <= '0;
            r_header        <= '0;
            r_keep          <= '0;
            r_cnt           <= '0;
            r_timeout_pulse <= 1'b0;
            r_keep_err      <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_timeout_pulse <= w_timeout;
            r_keep_err      <= w_capture && !keep_is_legal(64'(w_win_keep));
            if (w_capture) begin
                r_header   <= w_win_header;
                r_keep     <= w_win_keep;
                r_grant_id <= w_pick_idx;
            end
            // The source just served drops to lowest priority.
            if (w_release) begin
                r_rr_ptr <= (r_grant_id == c_idx_wd'(N_SRC - 1)) ? '0
                                                                  : r_grant_id + c_idx_wd'(1);
            end
            if (w_enter_wait) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT_EOP) begin
                r_cnt <= r_cnt + c_cnt_wd'(1);
            end
        end
    end

    // Reset also masks the picker so no source sees an accept while rst is high.
    assign bus.req_ready     = (r_state == ST_IDLE && !rst) ? w_pick_onehot : '0;
    assign bus.valid_insert  = (r_state == ST_OFFER);
    assign bus.header_insert = r_header;
    assign bus.keep_insert   = r_keep;
    assign grant_id          = r_grant_id;
    assign busy              = (r_state != ST_IDLE);
    assign timeout_pulse     = r_timeout_pulse;
    assign keep_err          = r_keep_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_header_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_stream_header_arbiter
// Brief   : Directed bench with a packet-level reference model and per-cycle compare.
// Revision: 1.0
// ============================================================================
module tb_axi_stream_header_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] grant_id;
    logic       busy, timeout_pulse, keep_err;

    logic [DW-1:0] hdr [N];
    logic [KW-1:0] kp  [N];

    int errors = 0;
    int checks = 0;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    axi_stream_header_arbiter_if #(.DATA_WD(DW), .DATA_BYTE_WD(KW), .N_SRC(N)) bus ();

    assign bus.req_header = {hdr[3], hdr[2], hdr[1], hdr[0]};
    assign bus.req_keep   = {kp[3], kp[2], kp[1], kp[0]};

    axi_stream_header_arbiter #(
        .DATA_WD(DW), .DATA_BYTE_WD(KW), .N_SRC(N), .EOP_TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse),
        .keep_err      (keep_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_owner = -1;
    bit            m_offer = 1'b0;
    int            m_ptr   = 0;
    int            m_wait  = 0;
    int            m_gid   = 0;
    logic [DW-1:0] m_hdr   = '0;
    logic [KW-1:0] m_keep  = '0;
    bit            m_tp    = 1'b0;
    bit            m_ke    = 1'b0;
    int            grants[$];

    function automatic int pick(input int ptr, input logic [N-1:0] v);
        for (int d = 0; d < N; d++) begin
            if (v[(ptr + d) % N]) return (ptr + d) % N;
        end
        return -1;
    endfunction

    function automatic bit keep_ok(input logic [KW-1:0] k);
        int n = 0;
        while (n < KW && k[n]) n++;
        for (int b = n; b < KW; b++) begin
            if (k[b]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit eop;
        int w;
        if (rst) begin
            m_owner = -1; m_offer = 1'b0; m_ptr = 0; m_wait = 0; m_gid = 0;
            m_hdr = '0; m_keep = '0; m_tp = 1'b0; m_ke = 1'b0;
        end else begin
            eop  = bus.mon_valid && bus.mon_ready && bus.mon_last;
            m_tp = 1'b0;
            m_ke = 1'b0;
            if (m_owner < 0) begin
                w = pick(m_ptr, bus.req_valid);
                if (w >= 0) begin
                    m_owner = w; m_gid = w; m_offer = 1'b1;
                    m_hdr = hdr[w]; m_keep = kp[w]; m_ke = !keep_ok(kp[w]);
                    grants.push_back(w);
                end
            end else if (m_offer) begin
                if (bus.ready_insert) begin
                    m_offer = 1'b0;
                    m_wait  = 0;
                    if (eop) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
                end
            end else begin
                m_wait++;
                if (eop || m_wait == TO) begin
                    m_tp    = !eop;
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] exp_rdy;
        int w;
        exp_rdy = '0;
        if (!rst && m_owner < 0) begin
            w = pick(m_ptr, bus.req_valid);
            if (w >= 0) exp_rdy[w] = 1'b1;
        end
        check("req_ready",     bus.req_ready,     exp_rdy);
        check("valid_insert",  bus.valid_insert,  (m_owner >= 0) && m_offer);
        check("header_insert", bus.header_insert, m_hdr);
        check("keep_insert",   bus.keep_insert,   m_keep);
        check("grant_id",      grant_id,          m_gid);
        check("busy",          busy,              m_owner >= 0);
        check("timeout_pulse", timeout_pulse,     m_tp);
        check("keep_err",      keep_err,          m_ke);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eop_beat();
        bus.mon_valid = 1'b1; bus.mon_ready = 1'b1; bus.mon_last = 1'b1;
        tick();
        bus.mon_valid = 1'b0; bus.mon_ready = 1'b0; bus.mon_last = 1'b0;
    endtask

    initial begin : stim
        int pulses;
        int pulse_at;
        for (int i = 0; i < N; i++) begin hdr[i] = '0; kp[i] = '0; end
        bus.ready_insert = 1'b0;
        bus.mon_valid = 1'b0; bus.mon_ready = 1'b0; bus.mon_last = 1'b0;
        bus.req_valid = 4'b0001;
        #12;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_valid_insert", bus.valid_insert, 0);
        bus.req_valid = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
        eop_beat();
        check("idle_ignores_last", busy, 0);

        // Single source, full handshake.
        hdr[0] = 32'hA1B2C3D4; kp[0] = 4'b1111;
        bus.ready_insert = 1'b1; bus.req_valid = 4'b0001;
        #1 check("s1_req_ready", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = 4'b0000;
        check("s1_valid_insert", bus.valid_insert, 1);
        check("s1_header", bus.header_insert, 32'hA1B2C3D4);
        tick();
        check("s1_wait_busy", busy, 1);
        check("s1_wait_valid", bus.valid_insert, 0);
        tick(); tick();
        eop_beat();
        check("s1_back_idle", busy, 0);

        // All sources requesting: rotation from a fresh pointer.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < N; i++) begin hdr[i] = {8'(i + 1), 24'hC0FFEE}; kp[i] = 4'b1111; end
        kp[3] = 4'b0111;
        grants.delete();
        bus.req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("s2_grant_order", grant_id, exp_order[g]);
            repeat (4) tick();
            if (g == 4) bus.req_valid = 4'b0000;
            eop_beat();
        end
        check("s2_grant_count", grants.size(), 5);
        for (int g = 0; g < 5; g++) check("s2_model_order", grants[g], exp_order[g]);

        // Back-pressure in OFFER for 7 cycles.
        bus.ready_insert = 1'b0;
        hdr[2] = 32'h5555AAAA; kp[2] = 4'b0011;
        bus.req_valid = 4'b0100;
        #1 check("s3_req_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b1011;
        for (int k = 0; k < 7; k++) begin
            check("s3_hold_valid", bus.valid_insert, 1);
            check("s3_hold_header", bus.header_insert, 32'h5555AAAA);
            check("s3_hold_keep", bus.keep_insert, 4'b0011);
            check("s3_no_ready", bus.req_ready, 0);
            tick();
        end
        bus.req_valid = 4'b0000; bus.ready_insert = 1'b1;
        tick();
        eop_beat();

        // EOP timeout.
        hdr[1] = 32'hDEADBEEF; kp[1] = 4'b0001;
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        pulses = 0; pulse_at = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (timeout_pulse === 1'b1) begin
                pulses++;
                if (pulse_at < 0) pulse_at = k;
            end
        end
        check("s4_pulse_count", pulses, 1);
        check("s4_pulse_cycle", pulse_at, 16);
        check("s4_idle", busy, 0);
        bus.req_valid = 4'b0101;
        #1 check("s4_next_source", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        eop_beat();

        // Illegal keep is flagged and forwarded.
        hdr[2] = 32'h0BADF00D; kp[2] = 4'b0101;
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = 4'b0000;
        check("s5_keep_err", keep_err, 1);
        check("s5_keep_fwd", bus.keep_insert, 4'b0101);
        check("s5_grant", grant_id, 2);
        tick();
        check("s5_keep_err_clear", keep_err, 0);
        eop_beat();

        // Reset mid-packet.
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = 4'b0000;
        tick(); tick();
        check("s6_in_wait", busy, 1);
        bus.req_valid = 4'b1111;
        rst = 1'b1;
        #1;
        check("s6_rst_busy", busy, 0);
        check("s6_rst_valid", bus.valid_insert, 0);
        check("s6_rst_grant", grant_id, 0);
        check("s6_rst_header", bus.header_insert, 0);
        check("s6_rst_keep", bus.keep_insert, 0);
        check("s6_rst_ready", bus.req_ready, 0);
        check("s6_rst_tp", timeout_pulse, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1 check("s6_first_after_rst", bus.req_ready, 4'b0001);
        tick();
        check("s6_grant0", grant_id, 0);
        bus.req_valid = 4'b0000;
        tick();
        eop_beat();
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
